// File: rtl/fp32_norm_sequencer_if.sv
// Handshake bundle for fp32_norm_sequencer: operand channel, result channel and busy status.
// master = producer/consumer side, slave = the sequencer.
interface fp32_norm_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [24:0] res;
  logic [7:0]  exp_base;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] man_res;
  logic [7:0]  exp_res;
  logic        overflow;
  logic        busy;

  modport master (
    output in_valid, res, exp_base, out_ready,
    input  in_ready, out_valid, man_res, exp_res, overflow, busy
  );

  modport slave (
    input  in_valid, res, exp_base, out_ready,
    output in_ready, out_valid, man_res, exp_res, overflow, busy
  );
endinterface

// File: rtl/fp32_norm_sequencer.sv
// Iterative FP32 post-add normalizer: up to SHIFT_PER_CYCLE left shifts per clock, one op in flight.
// Optional macro NORM_ZERO_DETECT_EN sends an all-zero mantissa straight to DONE.
module fp32_norm_sequencer #(
  parameter int unsigned SHIFT_PER_CYCLE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  fp32_norm_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e      state_q, state_d;
  // Bit 24 of the work mantissa is always zero after capture, so only 24 bits are kept.
  logic [23:0] m_q, m_d;
  logic [8:0]  e_q, e_d;
  logic [23:0] m_sh;
  logic [8:0]  e_sh;

  // Chained shift steps; once a step's condition fails the rest stay no-ops.
  always_comb begin
    m_sh = m_q;
    e_sh = e_q;
    for (int unsigned i = 0; i < SHIFT_PER_CYCLE; i++) begin
      if (!m_sh[23] && (e_sh != 9'd0)) begin
        m_sh = {m_sh[22:0], 1'b0};
        e_sh = e_sh - 9'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    e_d     = e_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          if (bus.res[24]) begin
            m_d     = bus.res[24:1];
            e_d     = {1'b0, bus.exp_base} + 9'd1;
            state_d = StDone;
          end
`ifdef NORM_ZERO_DETECT_EN
          else if (bus.res == 25'd0) begin
            m_d     = '0;
            e_d     = '0;
            state_d = StDone;
          end
`endif
          else begin
            m_d     = bus.res[23:0];
            e_d     = {1'b0, bus.exp_base};
            state_d = (bus.res[23] || (bus.exp_base == 8'd0)) ? StDone : StShift;
          end
        end
      end
      StShift: begin
        m_d = m_sh;
        e_d = e_sh;
        if (m_sh[23] || (e_sh == 9'd0)) state_d = StDone;
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      m_q     <= '0;
      e_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      e_q     <= e_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle) && !rst;
  assign bus.out_valid = (state_q == StDone);
  assign bus.man_res   = m_q;
  assign bus.exp_res   = e_q[7:0];
  assign bus.overflow  = (e_q >= 9'd255);
  assign bus.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_fp32_norm_sequencer.sv
// Scoreboard bench for fp32_norm_sequencer: driver pushes expected results, monitor pops on handshake.
module tb_fp32_norm_sequencer;
  localparam int unsigned S = 1;

  typedef struct {
    logic [23:0] man;
    logic [7:0]  e;
    logic        ovf;
    int          lat;
    int          stamp;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   pass = 0;
  exp_t sb[$];
  exp_t f;
  logic prev_v = 1'b0;
  logic prev_hs = 1'b0;
  logic [23:0] held_man;
  logic [7:0]  held_exp;
  logic        held_ovf;

  fp32_norm_sequencer_if bus ();

  fp32_norm_sequencer #(.SHIFT_PER_CYCLE(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Monitor: latency on rise of out_valid, stability while held, result on handshake.
  always @(negedge clk) begin
    if (rst) begin
      prev_v  = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (prev_hs) chk("valid_drop", {31'd0, bus.out_valid}, 32'd0);
      if (bus.out_valid) begin
        if (!prev_v || prev_hs) begin
          if (sb.size() == 0) begin
            total++;
            $display("FAIL spurious_out: got out_valid with no pending op (cycle %0d)", cyc);
          end else begin
            f = sb[0];
            chk("latency", cyc - f.stamp, f.lat);
          end
        end else begin
          chk("hold_man", {8'd0, bus.man_res}, {8'd0, held_man});
          chk("hold_exp", {24'd0, bus.exp_res}, {24'd0, held_exp});
          chk("hold_ovf", {31'd0, bus.overflow}, {31'd0, held_ovf});
        end
        held_man = bus.man_res;
        held_exp = bus.exp_res;
        held_ovf = bus.overflow;
        if (bus.out_ready && sb.size() != 0) begin
          f = sb.pop_front();
          chk("man_res", {8'd0, bus.man_res}, {8'd0, f.man});
          chk("exp_res", {24'd0, bus.exp_res}, {24'd0, f.e});
          chk("overflow", {31'd0, bus.overflow}, {31'd0, f.ovf});
        end
      end
      prev_v  = bus.out_valid;
      prev_hs = bus.out_valid && bus.out_ready;
    end
  end

  // k = number of left shifts the op needs; 0 means the direct path.
  task automatic send(input logic [24:0] r, input logic [7:0] eb, input logic [23:0] m,
                      input logic [7:0] e, input logic o, input int k, input bit track);
    int   n = 0;
    exp_t x;
    @(negedge clk);
    bus.res      = r;
    bus.exp_base = eb;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      total++;
      $display("FAIL accept_timeout: in_ready low for %0d cycles, required 1", n);
      bus.in_valid = 1'b0;
      return;
    end
    if (track) begin
      x.man   = m;
      x.e     = e;
      x.ovf   = o;
      x.lat   = (k == 0) ? 1 : 1 + (k + int'(S) - 1) / int'(S);
      x.stamp = cyc;
      sb.push_back(x);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      $display("FAIL done_timeout: %0d results pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic run(input logic [24:0] r, input logic [7:0] eb, input logic [23:0] m,
                     input logic [7:0] e, input logic o, input int k);
    send(r, eb, m, e, o, k, 1'b1);
    wait_done();
  endtask

  initial begin
    int n;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.res       = '0;
    bus.exp_base  = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_man", {8'd0, bus.man_res}, 32'd0);
    chk("rst_exp", {24'd0, bus.exp_res}, 32'd0);
    chk("rst_ovf", {31'd0, bus.overflow}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    rst = 1'b0;
    #1 chk("in_ready_after_rst", {31'd0, bus.in_ready}, 32'd1);

    //   res            exp     man           exp     ovf   shifts
    run(25'h0800000, 8'd127, 24'h800000, 8'd127, 1'b0, 0);
    run(25'h1000001, 8'd127, 24'h800000, 8'd128, 1'b0, 0);
    run(25'h0000001, 8'd100, 24'h800000, 8'd77,  1'b0, 23);
    run(25'h0000100, 8'd10,  24'h040000, 8'd0,   1'b0, 10);
    run(25'h1000000, 8'd254, 24'h800000, 8'd255, 1'b1, 0);
    run(25'h1000000, 8'd255, 24'h800000, 8'd0,   1'b1, 0);
    run(25'h0400000, 8'd0,   24'h400000, 8'd0,   1'b0, 0);
    run(25'h0C00000, 8'd255, 24'hC00000, 8'd255, 1'b1, 0);
    run(25'h0012345, 8'd20,  24'h91A280, 8'd13,  1'b0, 7);
`ifdef NORM_ZERO_DETECT_EN
    run(25'h0000000, 8'd50,  24'h000000, 8'd0,   1'b0, 0);
`else
    run(25'h0000000, 8'd50,  24'h000000, 8'd0,   1'b0, 50);
`endif

    // Back-pressure: result must hold and no new op may be accepted.
    bus.out_ready = 1'b0;
    send(25'h0800000, 8'd3, 24'h800000, 8'd3, 1'b0, 0, 1'b1);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (10) begin
      @(negedge clk);
      chk("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("hold_busy", {31'd0, bus.busy}, 32'd1);
    end
    bus.out_ready = 1'b1;
    wait_done();

    // Reset mid-SHIFT discards the op.
    send(25'h0000001, 8'd100, 24'h0, 8'd0, 1'b0, 23, 1'b0);
    repeat (5) @(negedge clk);
    chk("busy_in_shift", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("midrst_man", {8'd0, bus.man_res}, 32'd0);
    rst = 1'b0;
    #1 chk("midrst_in_ready_after", {31'd0, bus.in_ready}, 32'd1);
    repeat (30) @(negedge clk);

    run(25'h0200000, 8'd5, 24'h800000, 8'd3, 1'b0, 2);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", pass, total);
    $fatal(1);
  end
endmodule
